// File: rtl/ioexp_link_ctrl.sv
// ioexp_link_ctrl
// Moves bytes in both directions between the UART core and the IB I/O-expander
// emulation. UART->meter bytes are queued in a small FIFO and handed to the
// meter one at a time over a 4-phase handshake; meter->UART bytes are captured,
// passed to the UART transmitter, then acknowledged back to the meter.
// Meter-side handshake inputs come from the PROG domain and are synchronized.

module ioexp_link_ctrl #(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 80000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   // UART receiver side
   input  logic [7:0] uart_rx_data,
   input  logic       uart_rx_valid,
   // UART transmitter side
   output logic [7:0] uart_tx_data,
   output logic       uart_tx_valid,
   input  logic       uart_tx_ready,
   // Expander, meter-bound direction
   output logic [7:0] exp_tx_data,
   output logic       exp_tx_data_available,
   input  logic       exp_tx_data_ack_n,
   // Expander, meter-originated direction
   input  logic [7:0] exp_rx_data,
   input  logic       exp_rx_data_available,
   output logic       exp_tx_ack,
   // Status
   input  logic       err_clr,
   output logic       fifo_overflow,
   output logic       timeout_err,
   output logic       busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      D_IDLE    = 2'd0,
      D_PRESENT = 2'd1,
      D_RELEASE = 2'd2
   } ds_state_t;

   typedef enum logic [1:0] {
      U_IDLE = 2'd0,
      U_SEND = 2'd1,
      U_ACK  = 2'd2
   } us_state_t;

   // ------------------------------------------------------------------
   // Synchronizers for the asynchronous meter handshake inputs
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] ack_n_sync_q;
   logic [SYNC_STAGES-1:0] avail_sync_q;
   logic                   ack_n_s;
   logic                   avail_s;

   // Shift each input through SYNC_STAGES flops; reset to the idle levels.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_n_sync_q <= '1;
         avail_sync_q <= '0;
      end else begin
         ack_n_sync_q <= {ack_n_sync_q[SYNC_STAGES-2:0], exp_tx_data_ack_n};
         avail_sync_q <= {avail_sync_q[SYNC_STAGES-2:0], exp_rx_data_available};
      end
   end

   assign ack_n_s = ack_n_sync_q[SYNC_STAGES-1];
   assign avail_s = avail_sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Downstream FIFO
   // ------------------------------------------------------------------
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push;
   logic          pop;
   logic          drop;

   ds_state_t     ds_state_q;
   us_state_t     us_state_q;

   // Push/pop decisions; a full FIFO still accepts a byte when a pop frees a slot.
   always_comb begin
      pop      = (ds_state_q == D_IDLE) && (count_q != '0);
      push     = uart_rx_valid && ((count_q != FIFO_FULL) || pop);
      drop     = uart_rx_valid && !push;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage write port; no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= uart_rx_data;
      end
   end

   // FIFO pointer and occupancy registers; pointers wrap naturally (power of 2).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // ------------------------------------------------------------------
   // Downstream FSM: present FIFO bytes to the meter
   // ------------------------------------------------------------------
   logic [TW-1:0] ds_tmr_q;
   logic [7:0]    exp_tx_data_q;
   logic          exp_tx_avail_q;
   logic          ds_timeout;

   assign ds_timeout = (ds_state_q != D_IDLE) && (ds_tmr_q == TMR_LAST);

   // Pop a byte, raise available, then walk the ack_n low/high handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         ds_state_q     <= D_IDLE;
         ds_tmr_q       <= '0;
         exp_tx_data_q  <= '0;
         exp_tx_avail_q <= 1'b0;
      end else begin
         case (ds_state_q)
            D_IDLE: begin
               ds_tmr_q <= '0;
               if (pop) begin
                  exp_tx_data_q  <= fifo_mem[rd_ptr_q];
                  exp_tx_avail_q <= 1'b1;
                  ds_state_q     <= D_PRESENT;
               end
            end
            D_PRESENT: begin
               if (ds_timeout) begin
                  // Meter never took the byte: drop it and give up.
                  exp_tx_avail_q <= 1'b0;
                  ds_tmr_q       <= '0;
                  ds_state_q     <= D_IDLE;
               end else if (!ack_n_s) begin
                  exp_tx_avail_q <= 1'b0;
                  ds_tmr_q       <= '0;
                  ds_state_q     <= D_RELEASE;
               end else begin
                  ds_tmr_q <= ds_tmr_q + 1'b1;
               end
            end
            D_RELEASE: begin
               if (ds_timeout || ack_n_s) begin
                  ds_tmr_q   <= '0;
                  ds_state_q <= D_IDLE;
               end else begin
                  ds_tmr_q <= ds_tmr_q + 1'b1;
               end
            end
            default: begin
               exp_tx_avail_q <= 1'b0;
               ds_tmr_q       <= '0;
               ds_state_q     <= D_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Upstream FSM: forward meter bytes to the UART transmitter
   // ------------------------------------------------------------------
   logic [TW-1:0] us_tmr_q;
   logic [7:0]    uart_tx_data_q;
   logic          uart_tx_valid_q;
   logic          exp_tx_ack_q;
   logic          us_timeout;

   assign us_timeout = (us_state_q == U_ACK) && (us_tmr_q == TMR_LAST);

   // Capture the meter byte, hand it to the UART, then ack until available drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         us_state_q      <= U_IDLE;
         us_tmr_q        <= '0;
         uart_tx_data_q  <= '0;
         uart_tx_valid_q <= 1'b0;
         exp_tx_ack_q    <= 1'b0;
      end else begin
         case (us_state_q)
            U_IDLE: begin
               us_tmr_q <= '0;
               if (avail_s) begin
                  // The meter holds exp_rx_data stable before raising available.
                  uart_tx_data_q  <= exp_rx_data;
                  uart_tx_valid_q <= 1'b1;
                  us_state_q      <= U_SEND;
               end
            end
            U_SEND: begin
               // Local UART: wait as long as it takes, no timer here.
               us_tmr_q <= '0;
               if (uart_tx_ready) begin
                  uart_tx_valid_q <= 1'b0;
                  exp_tx_ack_q    <= 1'b1;
                  us_state_q      <= U_ACK;
               end
            end
            U_ACK: begin
               if (us_timeout || !avail_s) begin
                  exp_tx_ack_q <= 1'b0;
                  us_tmr_q     <= '0;
                  us_state_q   <= U_IDLE;
               end else begin
                  us_tmr_q <= us_tmr_q + 1'b1;
               end
            end
            default: begin
               uart_tx_valid_q <= 1'b0;
               exp_tx_ack_q    <= 1'b0;
               us_tmr_q        <= '0;
               us_state_q      <= U_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Sticky error flags
   // ------------------------------------------------------------------
   logic fifo_overflow_q;
   logic timeout_err_q;

   // Set events take priority over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_overflow_q <= 1'b0;
         timeout_err_q   <= 1'b0;
      end else begin
         if (drop) begin
            fifo_overflow_q <= 1'b1;
         end else if (err_clr) begin
            fifo_overflow_q <= 1'b0;
         end
         if (ds_timeout || us_timeout) begin
            timeout_err_q <= 1'b1;
         end else if (err_clr) begin
            timeout_err_q <= 1'b0;
         end
      end
   end

   assign uart_tx_data          = uart_tx_data_q;
   assign uart_tx_valid         = uart_tx_valid_q;
   assign exp_tx_data           = exp_tx_data_q;
   assign exp_tx_data_available = exp_tx_avail_q;
   assign exp_tx_ack            = exp_tx_ack_q;
   assign fifo_overflow         = fifo_overflow_q;
   assign timeout_err           = timeout_err_q;
   assign busy                  = (ds_state_q != D_IDLE) || (us_state_q != U_IDLE) ||
                                  (count_q != '0);

endmodule

// File: tb/tb_ioexp_link_ctrl.sv
// Directed testbench for ioexp_link_ctrl. Inputs are driven and outputs are
// sampled on the falling clock edge; expected values are hand-derived.

module tb_ioexp_link_ctrl;

   localparam int FIFO_DEPTH     = 8;
   localparam int TIMEOUT_CYCLES = 100;
   localparam int SYNC_STAGES    = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] uart_rx_data;
   logic       uart_rx_valid;
   logic [7:0] uart_tx_data;
   logic       uart_tx_valid;
   logic       uart_tx_ready;
   logic [7:0] exp_tx_data;
   logic       exp_tx_data_available;
   logic       exp_tx_data_ack_n;
   logic [7:0] exp_rx_data;
   logic       exp_rx_data_available;
   logic       exp_tx_ack;
   logic       err_clr;
   logic       fifo_overflow;
   logic       timeout_err;
   logic       busy;

   int vec_cnt        = 0;
   int miscompare_cnt = 0;

   always #5 clk = ~clk;

   ioexp_link_ctrl #(
      .FIFO_DEPTH    (FIFO_DEPTH),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .uart_rx_data         (uart_rx_data),
      .uart_rx_valid        (uart_rx_valid),
      .uart_tx_data         (uart_tx_data),
      .uart_tx_valid        (uart_tx_valid),
      .uart_tx_ready        (uart_tx_ready),
      .exp_tx_data          (exp_tx_data),
      .exp_tx_data_available(exp_tx_data_available),
      .exp_tx_data_ack_n    (exp_tx_data_ack_n),
      .exp_rx_data          (exp_rx_data),
      .exp_rx_data_available(exp_rx_data_available),
      .exp_tx_ack           (exp_tx_ack),
      .err_clr              (err_clr),
      .fifo_overflow        (fifo_overflow),
      .timeout_err          (timeout_err),
      .busy                 (busy)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vec_cnt++;
      if (obs !== expv) begin
         miscompare_cnt++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle receive strobe; called and returns on a falling edge.
   task automatic strobe(input logic [7:0] b);
      uart_rx_data  = b;
      uart_rx_valid = 1'b1;
      tick(1);
      uart_rx_valid = 1'b0;
   endtask

   task automatic wait_avail(input logic lvl, input int limit);
      int n;
      n = 0;
      while (exp_tx_data_available !== lvl && n < limit) begin
         tick(1);
         n++;
      end
   endtask

   // Meter side of one 4-phase transfer; leaves ack_n released.
   task automatic meter_take(output logic [7:0] b);
      wait_avail(1'b1, 20);
      check_val("take_avail_hi", 32'(exp_tx_data_available), 32'h1);
      b = exp_tx_data;
      exp_tx_data_ack_n = 1'b0;
      wait_avail(1'b0, 20);
      check_val("take_avail_lo", 32'(exp_tx_data_available), 32'h0);
      exp_tx_data_ack_n = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_tx_data"},  32'(uart_tx_data), 32'h0);
      check_val({tag, "_tx_valid"}, 32'(uart_tx_valid), 32'h0);
      check_val({tag, "_exp_data"}, 32'(exp_tx_data), 32'h0);
      check_val({tag, "_exp_avail"}, 32'(exp_tx_data_available), 32'h0);
      check_val({tag, "_exp_ack"},  32'(exp_tx_ack), 32'h0);
      check_val({tag, "_ovf"},      32'(fifo_overflow), 32'h0);
      check_val({tag, "_tmo"},      32'(timeout_err), 32'h0);
      check_val({tag, "_busy"},     32'(busy), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int         n;

      rst                   = 1'b1;
      uart_rx_data          = 8'h00;
      uart_rx_valid         = 1'b0;
      uart_tx_ready         = 1'b0;
      exp_tx_data_ack_n     = 1'b1;
      exp_rx_data           = 8'h00;
      exp_rx_data_available = 1'b0;
      err_clr               = 1'b0;
      tick(3);
      check_all_zero("reset");
      rst = 1'b0;
      tick(2);

      // ---- Downstream single byte, latency and handshake ----
      strobe(8'hA5);
      check_val("ds_lat_n1_avail", 32'(exp_tx_data_available), 32'h0);
      tick(1);
      check_val("ds_lat_n2_avail", 32'(exp_tx_data_available), 32'h1);
      check_val("ds_lat_n2_data", 32'(exp_tx_data), 32'hA5);
      check_val("ds_busy", 32'(busy), 32'h1);
      exp_tx_data_ack_n = 1'b0;
      wait_avail(1'b0, 3);
      check_val("ds_ack_drop", 32'(exp_tx_data_available), 32'h0);
      exp_tx_data_ack_n = 1'b1;
      n = 0;
      while (busy && n < 6) begin
         tick(1);
         n++;
      end
      check_val("ds_idle_busy", 32'(busy), 32'h0);

      // ---- Overflow: one byte held by the meter, then 9 strobes ----
      strobe(8'hF0);
      wait_avail(1'b1, 10);
      check_val("ovf_pre_data", 32'(exp_tx_data), 32'hF0);
      for (int i = 1; i <= 8; i++) strobe(8'(i));
      check_val("ovf_before", 32'(fifo_overflow), 32'h0);
      strobe(8'h09);
      check_val("ovf_after", 32'(fifo_overflow), 32'h1);
      meter_take(b);
      check_val("ovf_drain_pre", 32'(b), 32'hF0);
      for (int i = 1; i <= 8; i++) begin
         meter_take(b);
         check_val("ovf_drain", 32'(b), 32'(i));
      end
      tick(6);
      check_val("ovf_drained_busy", 32'(busy), 32'h0);
      check_val("ovf_sticky", 32'(fifo_overflow), 32'h1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check_val("ovf_clr", 32'(fifo_overflow), 32'h0);

      // ---- Full FIFO with a push on the same cycle as a pop ----
      strobe(8'hE0);
      wait_avail(1'b1, 10);
      for (int i = 0; i < 8; i++) strobe(8'(8'h11 + i));
      check_val("full_pre_data", 32'(exp_tx_data), 32'hE0);
      exp_tx_data_ack_n = 1'b0;
      wait_avail(1'b0, 5);
      check_val("full_ack_drop", 32'(exp_tx_data_available), 32'h0);
      exp_tx_data_ack_n = 1'b1;
      // Two sync flops, one edge to leave D_RELEASE, the pop on the next edge.
      tick(3);
      uart_rx_data  = 8'h55;
      uart_rx_valid = 1'b1;
      tick(1);
      uart_rx_valid = 1'b0;
      check_val("full_pop_ovf", 32'(fifo_overflow), 32'h0);
      check_val("full_pop_avail", 32'(exp_tx_data_available), 32'h1);
      check_val("full_pop_data", 32'(exp_tx_data), 32'h11);
      for (int i = 0; i < 8; i++) begin
         meter_take(b);
         check_val("full_drain", 32'(b), 32'(8'h11 + i));
      end
      meter_take(b);
      check_val("full_last", 32'(b), 32'h55);
      tick(6);
      check_val("full_busy", 32'(busy), 32'h0);

      // ---- Upstream byte ----
      exp_rx_data           = 8'h3C;
      exp_rx_data_available = 1'b1;
      uart_tx_ready         = 1'b0;
      tick(20);
      check_val("us_valid_held", 32'(uart_tx_valid), 32'h1);
      check_val("us_data", 32'(uart_tx_data), 32'h3C);
      check_val("us_ack_early", 32'(exp_tx_ack), 32'h0);
      uart_tx_ready = 1'b1;
      tick(1);
      uart_tx_ready = 1'b0;
      check_val("us_ack_set", 32'(exp_tx_ack), 32'h1);
      check_val("us_valid_clr", 32'(uart_tx_valid), 32'h0);
      exp_rx_data_available = 1'b0;
      n = 0;
      while (exp_tx_ack && n < 6) begin
         tick(1);
         n++;
      end
      check_val("us_ack_clr", 32'(exp_tx_ack), 32'h0);
      tick(2);
      check_val("us_busy", 32'(busy), 32'h0);

      // ---- Downstream timeout ----
      check_val("tmo_pre", 32'(timeout_err), 32'h0);
      strobe(8'h77);
      wait_avail(1'b1, 10);
      n = 0;
      while (exp_tx_data_available && n < 200) begin
         n++;
         tick(1);
      end
      check_val("tmo_cycles", 32'(n), 32'd100);
      check_val("tmo_flag", 32'(timeout_err), 32'h1);
      check_val("tmo_data_hold", 32'(exp_tx_data), 32'h77);
      check_val("tmo_busy", 32'(busy), 32'h0);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check_val("tmo_clr", 32'(timeout_err), 32'h0);

      // ---- Reset in the middle of both handshakes ----
      strobe(8'h99);
      wait_avail(1'b1, 10);
      exp_rx_data           = 8'h5A;
      exp_rx_data_available = 1'b1;
      uart_tx_ready         = 1'b1;
      n = 0;
      while (!exp_tx_ack && n < 10) begin
         tick(1);
         n++;
      end
      check_val("mid_us_ack", 32'(exp_tx_ack), 32'h1);
      for (int i = 0; i < 9; i++) strobe(8'(8'hA0 + i));
      check_val("mid_ovf", 32'(fifo_overflow), 32'h1);
      check_val("mid_ds_avail", 32'(exp_tx_data_available), 32'h1);
      rst                   = 1'b1;
      exp_rx_data_available = 1'b0;
      uart_tx_ready         = 1'b0;
      tick(1);
      check_all_zero("midrst");
      rst = 1'b0;
      tick(6);
      check_val("post_rst_avail", 32'(exp_tx_data_available), 32'h0);
      check_val("post_rst_busy", 32'(busy), 32'h0);
      check_val("post_rst_ovf", 32'(fifo_overflow), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
      $finish;
   end

endmodule
